// File: rtl/ee465_mac_sequencer.sv
// Two-term sum-of-products sequencer (A0*B0 [+ A1*B1]) built on one shared WxW multiplier.
// Define MACSEQ_PIPE_EN to register the product between the multiplier and the adder.
module ee465_mac_sequencer #(
   parameter int W  = 8,
   parameter int RW = 2*W+1
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iSTART,
   input  logic          iSEL,
   input  logic [W-1:0]  iA0,
   input  logic [W-1:0]  iA1,
   input  logic [W-1:0]  iB0,
   input  logic [W-1:0]  iB1,
   output logic          oBUSY,
   output logic          oDONE,
   output logic [RW-1:0] oRESULT
);

`ifdef MACSEQ_PIPE_EN
   typedef enum logic [2:0] {IDLE, MUL0, PWAIT0, MUL1, PWAIT1} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL0, MUL1} state_t;
`endif

   state_t          state, next_state;
   logic [W-1:0]    a0_r, a1_r, b0_r, b1_r;
   logic            sel_r;
   logic [RW-1:0]   acc;
   logic [W-1:0]    mul_a, mul_b;
   logic [2*W-1:0]  prod;
   logic [RW-1:0]   prod_ext;
   logic [RW-1:0]   term;
   logic            load_ops, acc_load, res_load, res_sum, done_next;

   // Shared multiplier: second operand pair only while issuing the second product.
   assign mul_a    = (state == MUL1) ? a1_r : a0_r;
   assign mul_b    = (state == MUL1) ? b1_r : b0_r;
   assign prod     = mul_a * mul_b;
   assign prod_ext = RW'(prod);

`ifdef MACSEQ_PIPE_EN
   logic [RW-1:0] prod_p1;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) prod_p1 <= '0;
      else      prod_p1 <= prod_ext;
   end

   assign term = prod_p1;
`else
   assign term = prod_ext;
`endif

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state <= IDLE;
         oBUSY <= 1'b0;
         oDONE <= 1'b0;
      end else begin
         state <= next_state;
         oBUSY <= (next_state != IDLE);
         oDONE <= done_next;
      end
   end

   always_comb begin
      next_state = state;
      load_ops   = 1'b0;
      acc_load   = 1'b0;
      res_load   = 1'b0;
      res_sum    = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART) begin
               load_ops   = 1'b1;
               next_state = MUL0;
            end
         end
`ifdef MACSEQ_PIPE_EN
         MUL0:   next_state = PWAIT0;
         PWAIT0: begin
            acc_load = 1'b1;
            if (sel_r) begin
               next_state = MUL1;
            end else begin
               res_load   = 1'b1;
               done_next  = 1'b1;
               next_state = IDLE;
            end
         end
         MUL1:   next_state = PWAIT1;
         PWAIT1: begin
            res_load   = 1'b1;
            res_sum    = 1'b1;
            done_next  = 1'b1;
            next_state = IDLE;
         end
`else
         MUL0: begin
            acc_load = 1'b1;
            if (sel_r) begin
               next_state = MUL1;
            end else begin
               res_load   = 1'b1;
               done_next  = 1'b1;
               next_state = IDLE;
            end
         end
         MUL1: begin
            res_load   = 1'b1;
            res_sum    = 1'b1;
            done_next  = 1'b1;
            next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, accumulator and result register.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         a0_r    <= '0;
         a1_r    <= '0;
         b0_r    <= '0;
         b1_r    <= '0;
         sel_r   <= 1'b0;
         acc     <= '0;
         oRESULT <= '0;
      end else begin
         if (load_ops) begin
            a0_r  <= iA0;
            a1_r  <= iA1;
            b0_r  <= iB0;
            b1_r  <= iB1;
            sel_r <= iSEL;
         end
         if (acc_load) acc <= term;
         if (res_load) oRESULT <= res_sum ? (acc + term) : term;
      end
   end

endmodule

// File: tb/tb_ee465_mac_sequencer.sv
// Directed bench for ee465_mac_sequencer; latencies follow MACSEQ_PIPE_EN when defined.
module tb_ee465_mac_sequencer;

`ifdef MACSEQ_PIPE_EN
   localparam int LAT0 = 2;
   localparam int LAT1 = 4;
`else
   localparam int LAT0 = 1;
   localparam int LAT1 = 2;
`endif

   logic        clk = 1'b0;
   logic        rst, start, sel;
   logic [7:0]  a0, a1, b0, b1;
   logic        busy, done;
   logic [16:0] result;

   int n_vec = 0;
   int n_err = 0;

   ee465_mac_sequencer #(.W(8), .RW(17)) dut (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iSEL(sel),
      .iA0(a0), .iA1(a1), .iB0(b0), .iB1(b1),
      .oBUSY(busy), .oDONE(done), .oRESULT(result)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [7:0] x0, y0, x1, y1, input logic s);
      a0 = x0; b0 = y0; a1 = x1; b1 = y1; sel = s;
   endtask

   task automatic issue(input logic [7:0] x0, y0, x1, y1, input logic s);
      set_ops(x0, y0, x1, y1, s);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   int lat, ndone, last_c, extra;

   initial begin
      rst = 1'b1; start = 1'b0;
      set_ops(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      tick(); tick();
      check_vec("rst_busy",   busy,   0);
      check_vec("rst_done",   done,   0);
      check_vec("rst_result", result, 0);
      rst = 1'b0;
      tick();

      // sum of two products
      issue(8'd100, 8'd10, 8'd50, 8'd20, 1'b1);
      check_vec("t2_busy", busy, 1);
      wait_done(lat);
      check_vec("t2_lat",    lat,    LAT1);
      check_vec("t2_result", result, 2000);
      tick();
      check_vec("t2_done_pulse", done,   0);
      check_vec("t2_idle",       busy,   0);
      check_vec("t2_hold",       result, 2000);

      // single product
      issue(8'd100, 8'd10, 8'd50, 8'd20, 1'b0);
      wait_done(lat);
      check_vec("t3_lat",    lat,    LAT0);
      check_vec("t3_result", result, 1000);
      tick();

      // full-scale operands
      issue(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
      wait_done(lat);
      check_vec("t4_lat",    lat,    LAT1);
      check_vec("t4_result", result, 130050);
      tick();

      // start held high: one op every LAT1+1 cycles
      set_ops(8'd10, 8'd1, 8'd5, 8'd2, 1'b1);
      start = 1'b1;
      ndone = 0; last_c = 0;
      for (int c = 1; c <= 4*(LAT1+1); c++) begin
         tick();
         if (done) begin
            check_vec("t5_result", result, 20);
            if (last_c != 0) check_vec("t5_period", c - last_c, LAT1 + 1);
            else             check_vec("t5_first",  c,          LAT1 + 1);
            last_c = c;
            ndone++;
         end
      end
      start = 1'b0;
      check_vec("t5_count", ndone, 4);
      repeat (8) tick();
      check_vec("t5_idle", busy, 0);

      // operand change and extra start while busy
      issue(8'd3, 8'd4, 8'd5, 8'd6, 1'b1);
      set_ops(8'd200, 8'd200, 8'd200, 8'd200, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check_vec("t6_lat",    lat + 1, LAT1);
      check_vec("t6_result", result,  42);
      extra = 0;
      repeat (8) begin
         tick();
         if (done) extra++;
      end
      check_vec("t6_no_second", extra,  0);
      check_vec("t6_hold",      result, 42);

      // async reset in the second-product phase
      issue(8'd100, 8'd10, 8'd50, 8'd20, 1'b1);
      repeat (LAT1/2) tick();
      check_vec("t1_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check_vec("t1_busy",   busy,   0);
      check_vec("t1_done",   done,   0);
      check_vec("t1_result", result, 0);
      tick();
      rst = 1'b0;
      extra = 0;
      repeat (8) begin
         tick();
         if (done) extra++;
      end
      check_vec("t1_no_done", extra,  0);
      check_vec("t1_idle",    busy,   0);
      check_vec("t1_result2", result, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
